// File: rtl/cache_pkg.sv
// Shared cache definitions: address field layout, default tag/index widths,
// and the invalidate-handler FSM encoding (the cache controller's arbiter
// decodes the same encoding).
package cache_pkg;

  localparam int ADDR_BITS      = 16;
  localparam int OFFSET_BIT     = 0;
  localparam int INDEX_LSB      = 1;
  localparam int INDEX_MSB      = 7;
  localparam int TAG_LSB        = 8;
  localparam int TAG_MSB        = 15;
  localparam int TAG_BITS_DEF   = TAG_MSB - TAG_LSB + 1;
  localparam int INDEX_BITS_DEF = INDEX_MSB - INDEX_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_CLEAR   = 3'd4
  } inv_state_e;

endpackage

// File: rtl/inv_fifo.sv
// Pending-invalidate queue: circular buffer with wrapping pointers and a
// count register. Also reports whether the incoming entry already sits in
// the queue so duplicates can be coalesced.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (control only)
//   push, pop, wdata  enqueue / dequeue; push ignored when full
//   excl_head         leave the head entry out of the duplicate match
//   head              entry at the read pointer
//   full, empty       status derived from the registered count
//   match             wdata equals an occupied (non-excluded) entry
module inv_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             excl_head,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] offs;
  logic             occupied;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // A slot is occupied when its distance from the read pointer is below the
  // count; the power-of-2 depth makes the pointer subtraction wrap cleanly.
  always_comb begin
    match    = 1'b0;
    offs     = '0;
    occupied = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs     = PTR_W'(i) - rd_ptr_q;
      occupied = ({1'b0, offs} < count_q) && !(excl_head && (offs == '0));
      if (occupied && (mem_q[i] == wdata)) match = 1'b1;
    end
  end

endmodule

// File: rtl/cache_invalidate_handler.sv
// Cache-side invalidate receiver. Queues invalidate addresses from the
// coherenter, borrows the tag-array port, reads the indexed line and clears
// its valid bit when the stored tag matches.
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   inv_valid/inv_address/inv_ready   request intake (valid/ready)
//   inv_req/inv_grant            tag-array port arbitration
//   tag_rd_en/index, tag_rd_data read port (data one cycle after enable)
//   tag_wr_en/index/data         write port used to clear the valid bit
//   inv_done/inv_hit             retire pulse and hit qualifier
//   hit_count                    wrapping count of invalidations that hit
module cache_invalidate_handler
  import cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_BITS   = TAG_BITS_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inv_valid,
  input  logic [ADDR_BITS-1:0]  inv_address,
  output logic                  inv_ready,
  output logic                  inv_req,
  input  logic                  inv_grant,
  output logic                  tag_rd_en,
  output logic [INDEX_BITS-1:0] tag_rd_index,
  input  logic [TAG_BITS:0]     tag_rd_data,
  output logic                  tag_wr_en,
  output logic [INDEX_BITS-1:0] tag_wr_index,
  output logic [TAG_BITS:0]     tag_wr_data,
  output logic                  inv_done,
  output logic                  inv_hit,
  output logic [15:0]           hit_count
);

  localparam int ENTRY_W = TAG_BITS + INDEX_BITS;

  inv_state_e          state_q;
  logic [15:0]         hit_count_q;
  logic [TAG_BITS-1:0] tag_lat_q;

  logic [ENTRY_W-1:0]    req_entry, head;
  logic [TAG_BITS-1:0]   head_tag;
  logic [INDEX_BITS-1:0] head_idx;
  logic fifo_full, fifo_empty, fifo_match;
  logic push, pop, excl_head, hit;
  logic unused_offset;

  assign unused_offset = inv_address[OFFSET_BIT];
  assign req_entry = {inv_address[INDEX_LSB+INDEX_BITS +: TAG_BITS],
                      inv_address[INDEX_LSB +: INDEX_BITS]};
  assign head_tag  = head[ENTRY_W-1 -: TAG_BITS];
  assign head_idx  = head[INDEX_BITS-1:0];

  assign inv_ready = !fifo_full;
  // Duplicates are accepted but not stored; the queued copy covers them.
  assign push      = inv_valid && inv_ready && !fifo_match;
  // Once the head has been read, a new request for the same line must be
  // queued again, since the in-flight check may already have missed it.
  assign excl_head = (state_q == ST_READ) || (state_q == ST_COMPARE) ||
                     (state_q == ST_CLEAR);
  assign hit       = tag_rd_data[TAG_BITS] &&
                     (tag_rd_data[TAG_BITS-1:0] == head_tag);
  assign pop       = ((state_q == ST_COMPARE) && !hit) || (state_q == ST_CLEAR);

  inv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .excl_head (excl_head),
    .wdata     (req_entry),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .match     (fifo_match)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hit_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (!fifo_empty) state_q <= ST_REQ;
        ST_REQ:     if (inv_grant) state_q <= ST_READ;
        ST_READ:    state_q <= ST_COMPARE;
        ST_COMPARE: state_q <= hit ? ST_CLEAR : ST_IDLE;
        ST_CLEAR: begin
          state_q     <= ST_IDLE;
          hit_count_q <= hit_count_q + 1'b1;
        end
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_COMPARE && hit) tag_lat_q <= tag_rd_data[TAG_BITS-1:0];
  end

  // Outputs decode the registered state; only the miss retire depends on
  // the read data returned during COMPARE.
  always_comb begin
    inv_req      = (state_q != ST_IDLE);
    tag_rd_en    = 1'b0;
    tag_rd_index = '0;
    tag_wr_en    = 1'b0;
    tag_wr_index = '0;
    tag_wr_data  = '0;
    inv_done     = 1'b0;
    inv_hit      = 1'b0;
    case (state_q)
      ST_READ: begin
        tag_rd_en    = 1'b1;
        tag_rd_index = head_idx;
      end
      ST_COMPARE: inv_done = !hit;
      ST_CLEAR: begin
        tag_wr_en    = 1'b1;
        tag_wr_index = head_idx;
        tag_wr_data  = {1'b0, tag_lat_q};
        inv_done     = 1'b1;
        inv_hit      = 1'b1;
      end
      default: ;
    endcase
  end

  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_cache_invalidate_handler.sv
module tb_cache_invalidate_handler;

  logic        clock;
  logic        reset;
  logic        inv_valid;
  logic [15:0] inv_address;
  logic        inv_ready;
  logic        inv_req;
  logic        inv_grant;
  logic        tag_rd_en;
  logic [6:0]  tag_rd_index;
  logic [8:0]  tag_rd_data;
  logic        tag_wr_en;
  logic [6:0]  tag_wr_index;
  logic [8:0]  tag_wr_data;
  logic        inv_done;
  logic        inv_hit;
  logic [15:0] hit_count;

  int n_vec = 0;
  int n_err = 0;

  // Tag-array model with a backdoor preload port.
  logic [8:0] tag_mem [128];
  logic       bk_we;
  logic [6:0] bk_idx;
  logic [8:0] bk_data;
  logic [6:0] rd_log[$];

  cache_invalidate_handler dut (
    .clock        (clock),
    .reset        (reset),
    .inv_valid    (inv_valid),
    .inv_address  (inv_address),
    .inv_ready    (inv_ready),
    .inv_req      (inv_req),
    .inv_grant    (inv_grant),
    .tag_rd_en    (tag_rd_en),
    .tag_rd_index (tag_rd_index),
    .tag_rd_data  (tag_rd_data),
    .tag_wr_en    (tag_wr_en),
    .tag_wr_index (tag_wr_index),
    .tag_wr_data  (tag_wr_data),
    .inv_done     (inv_done),
    .inv_hit      (inv_hit),
    .hit_count    (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tag_rd_en) tag_rd_data <= tag_mem[tag_rd_index];
    if (tag_wr_en) tag_mem[tag_wr_index] <= tag_wr_data;
    else if (bk_we) tag_mem[bk_idx] <= bk_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [6:0] idx, input logic [8:0] data);
    bk_we = 1'b1; bk_idx = idx; bk_data = data;
    step();
    bk_we = 1'b0;
  endtask

  // Bounded observation window: counts retirements and logs read indices.
  task automatic run_count(input int cycles, output int ndone);
    ndone = 0;
    repeat (cycles) begin
      if (inv_done) ndone++;
      if (tag_rd_en) rd_log.push_back(tag_rd_index);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd;
    reset = 1'b0; inv_valid = 1'b0; inv_address = '0; inv_grant = 1'b1;
    bk_we = 1'b0; bk_idx = '0; bk_data = '0; tag_rd_data = '0;
    repeat (3) step();
    reset = 1'b1;
    chk("rst_ready", inv_ready, 1);
    chk("rst_req", inv_req, 0);
    chk("rst_rd_en", tag_rd_en, 0);
    chk("rst_wr_en", tag_wr_en, 0);
    chk("rst_done", inv_done, 0);
    chk("rst_hit", inv_hit, 0);
    chk("rst_hit_count", hit_count, 0);

    preload(7'h12, 9'h1AB);
    for (int i = 1; i <= 4; i++) preload(7'(i), 9'h000);

    // Hit: 0xAB24 -> tag 0xAB, index 0x12
    inv_valid = 1'b1; inv_address = 16'hAB24;
    chk("hit_ready", inv_ready, 1);
    step();                             // cycle N
    inv_valid = 1'b0;
    chk("hit_N_req", inv_req, 0);
    step();                             // N+1
    chk("hit_N1_req", inv_req, 1);
    chk("hit_N1_rd_en", tag_rd_en, 0);
    step();                             // N+2
    chk("hit_N2_rd_en", tag_rd_en, 1);
    chk("hit_N2_rd_idx", tag_rd_index, 7'h12);
    step();                             // N+3
    chk("hit_N3_done", inv_done, 0);
    chk("hit_N3_wr_en", tag_wr_en, 0);
    step();                             // N+4
    chk("hit_N4_wr_en", tag_wr_en, 1);
    chk("hit_N4_wr_idx", tag_wr_index, 7'h12);
    chk("hit_N4_wr_data", tag_wr_data, 9'h0AB);
    chk("hit_N4_done", inv_done, 1);
    chk("hit_N4_hit", inv_hit, 1);
    step();                             // N+5
    chk("hit_N5_req", inv_req, 0);
    chk("hit_N5_done", inv_done, 0);
    chk("hit_N5_count", hit_count, 1);
    chk("hit_mem", tag_mem[7'h12], 9'h0AB);

    // Miss: stored tag 0xAC
    preload(7'h12, 9'h1AC);
    inv_valid = 1'b1; inv_address = 16'hAB24;
    step();                             // N
    inv_valid = 1'b0;
    step(); step(); step();             // N+3
    chk("miss_N3_done", inv_done, 1);
    chk("miss_N3_hit", inv_hit, 0);
    chk("miss_N3_wr_en", tag_wr_en, 0);
    step();                             // N+4
    chk("miss_N4_wr_en", tag_wr_en, 0);
    chk("miss_N4_req", inv_req, 0);
    chk("miss_count", hit_count, 1);

    // Full / backpressure with grant low
    inv_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      inv_valid = 1'b1;
      inv_address = {8'(i), 7'(i), 1'b0};
      chk($sformatf("full_ready_%0d", i), inv_ready, 1);
      step();
    end
    inv_address = {8'h05, 7'h05, 1'b0};
    chk("full_ready_5a", inv_ready, 0);
    step();
    chk("full_ready_5b", inv_ready, 0);
    chk("full_req_wait", inv_req, 1);
    inv_valid = 1'b0;
    inv_grant = 1'b1;
    rd_log.delete();
    run_count(40, nd);
    chk("full_retire_cnt", nd, 4);
    chk("full_rd_cnt", rd_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("full_order_%0d", i), (rd_log.size() > i) ? rd_log[i] : 7'h7F, 7'(i + 1));
    chk("full_ready_after", inv_ready, 1);

    // Coalescing with grant low
    inv_grant = 1'b0;
    inv_valid = 1'b1; inv_address = 16'hAB24;
    step();
    inv_address = 16'hAB25;
    chk("coal_ready", inv_ready, 1);
    step();
    inv_valid = 1'b0;
    step(); step();
    inv_grant = 1'b1;
    rd_log.delete();
    run_count(30, nd);
    chk("coal_retire_cnt", nd, 1);
    chk("coal_rd_cnt", rd_log.size(), 1);

    // Duplicate of the head while it is in COMPARE
    inv_valid = 1'b1; inv_address = 16'hAB24;
    step();                             // N
    inv_valid = 1'b0;
    step(); step(); step();             // N+3 (COMPARE, miss)
    chk("dup_first_done", inv_done, 1);
    inv_valid = 1'b1; inv_address = 16'hAB24;
    chk("dup_ready", inv_ready, 1);
    step();
    inv_valid = 1'b0;
    run_count(20, nd);
    chk("dup_second_cnt", nd, 1);

    // Reset during CLEAR
    preload(7'h12, 9'h1AB);
    inv_valid = 1'b1; inv_address = 16'hAB24;
    step();                             // N
    inv_valid = 1'b0;
    step(); step(); step(); step();     // N+4 (CLEAR)
    chk("rc_clear_wr_en", tag_wr_en, 1);
    chk("rc_pre_count", hit_count, 1);
    reset = 1'b0;
    step();
    chk("rc_wr_en", tag_wr_en, 0);
    chk("rc_ready", inv_ready, 1);
    chk("rc_hit_count", hit_count, 0);
    chk("rc_req", inv_req, 0);
    chk("rc_done", inv_done, 0);
    reset = 1'b1;
    run_count(15, nd);
    chk("rc_no_retire", nd, 0);
    chk("rc_idle_req", inv_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_invalidate_handler.md
# cache_invalidate_handler

Cache-side receiver for coherence invalidations. It accepts invalidate addresses from the cache coherenter, queues them, and borrows the cache's tag-array port to clear the valid bit of any matching line. One instance sits in each of the two caches, between the coherenter output and that cache's tag array.

## Interface
Parameters:
- FIFO_DEPTH, 4: pending-invalidate queue depth; must be a power of 2, at least 2.
- TAG_BITS, 8: tag width; address bits 15:8.
- INDEX_BITS, 7: index width; address bits 7:1. Offset bit 0 is ignored.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- inv_valid  in  1  invalidate request strobe from the coherenter.
- inv_address  in  16  address to invalidate: {tag, index, offset}.
- inv_ready  out  1  high when the queue is not full. A request is taken when inv_valid && inv_ready.
- inv_req  out  1  request for the tag-array port.
- inv_grant  in  1  port granted by the cache controller. Held high until inv_req drops.
- tag_rd_en  out  1  tag-array read strobe.
- tag_rd_index  out  INDEX_BITS  read index.
- tag_rd_data  in  1+TAG_BITS  {valid, tag}. Valid on the cycle after tag_rd_en.
- tag_wr_en  out  1  tag-array write strobe.
- tag_wr_index  out  INDEX_BITS  write index.
- tag_wr_data  out  1+TAG_BITS  {1'b0, stored tag}.
- inv_done  out  1  one-cycle pulse when the head entry retires.
- inv_hit  out  1  qualified by inv_done: 1 means a line was cleared.
- hit_count  out  16  total invalidations that hit; wraps at 2^16.

## Operation
- Queue: circular FIFO of {tag, index}, with count register and wrapping read/write pointers.
  - inv_ready = (count != FIFO_DEPTH), computed from registered count only.
  - A push that arrives while full is not accepted, even if a pop happens in the same cycle.
- Coalescing: an accepted request is dropped (no push) when its {tag, index} equals a queued entry.
  - The head entry is excluded from the comparison while the FSM is in READ, COMPARE or CLEAR.
  - A dropped request still counts as accepted.
- FSM states: IDLE, REQ, READ, COMPARE, CLEAR.
  - IDLE -> REQ when count != 0.
  - REQ: inv_req=1. Moves to READ on the edge where inv_grant=1.
  - READ: tag_rd_en=1 and tag_rd_index=head.index for exactly one cycle, then COMPARE.
  - COMPARE: hit = tag_rd_data valid bit && tag == head.tag.
    - On hit: go to CLEAR and latch the stored tag.
    - On miss: inv_done=1, inv_hit=0, pop the head, go to IDLE.
  - CLEAR: tag_wr_en=1, tag_wr_index=head.index, tag_wr_data={0, latched tag}. Also inv_done=1, inv_hit=1, pop the head, hit_count+1, go to IDLE.
- inv_req is high in REQ, READ, COMPARE and CLEAR, and low in IDLE.
- A push and a pop in the same cycle leave count unchanged.

## Timing
- Reset (reset=0 at an edge): FSM goes to IDLE, pointers and count go to 0, hit_count goes to 0.
  - All outputs are 0, except inv_ready=1.
  - A reset during READ, COMPARE or CLEAR abandons the operation. No write is issued after the reset edge.
- Latency, starting from an empty queue with grant already high:
  - accept at cycle N
  - inv_req at N+1
  - READ at N+2
  - COMPARE at N+3
  - CLEAR with inv_done at N+4 on a hit, or inv_done at N+3 on a miss.
- Back-to-back service: IDLE lasts at least one cycle between entries, so inv_req drops for exactly one cycle.
- If inv_grant is low in REQ, the FSM waits indefinitely. Accepting new requests continues up to full.

## Structure
- Shared package cache_pkg holds:
  - address field ranges (tag 15:8, index 7:1, offset 0);
  - TAG_BITS and INDEX_BITS defaults;
  - the FSM state encoding, which is also used by the cache controller's arbiter.
- Sub-module inv_fifo contains the storage, pointers, count, full/empty flags and the parallel match output for coalescing.
- The top level contains the FSM, the compare logic and hit_count.

## Test plan
- Hit: line 0x12 holds {1, 0xAB}, grant tied high; send 0xAB24 -> tag write at index 0x12 with data {0, 0xAB}, inv_done and inv_hit at N+4, hit_count=1.
- Miss: stored tag 0xAC at index 0x12; send 0xAB24 -> no tag_wr_en, inv_done=1 and inv_hit=0 at N+3.
- Full/backpressure: grant low; send 5 distinct addresses -> inv_ready drops after the 4th and the 5th is held off; raise grant -> four retirements in FIFO order.
- Coalescing: grant low; send 0xAB24 then 0xAB25 -> one queue entry and one retirement.
- Head-in-service duplicate: send 0xAB24 while the head 0xAB24 is in COMPARE -> queued, two retirements.
- Reset mid-CLEAR: assert reset in the CLEAR cycle -> next cycle tag_wr_en=0, count=0, inv_ready=1, hit_count=0.
